// File: rtl/btb_ras_param_if.sv
// Lookup and update bundle between the fetch/decode stages and btb_ras_param.
// master = pipeline side (drives lookups and resolutions), slave = predictor.
interface btb_ras_param_if #(
  parameter int IDX_W = 5
);
  // IF-stage lookup
  logic             fetch_en;
  logic [31:0]      fetch_pc;
  logic             ret_en;
  logic             taken;
  logic [31:0]      ret_pc;
  logic [IDX_W-1:0] ret_index;
  // ID-stage resolution / update
  logic             operate_en;
  logic [31:0]      operate_pc;
  logic [IDX_W-1:0] operate_index;
  logic             pop_ras;
  logic             push_ras;
  logic             add_entry;
  logic             delete_entry;
  logic             pre_error;
  logic             pre_right;
  logic             target_error;
  logic             right_orien;
  logic [31:0]      right_target;

  modport master (
    output fetch_en, fetch_pc,
    output operate_en, operate_pc, operate_index, pop_ras, push_ras,
    output add_entry, delete_entry, pre_error, pre_right, target_error,
    output right_orien, right_target,
    input  ret_en, taken, ret_pc, ret_index
  );

  modport slave (
    input  fetch_en, fetch_pc,
    input  operate_en, operate_pc, operate_index, pop_ras, push_ras,
    input  add_entry, delete_entry, pre_error, pre_right, target_error,
    input  right_orien, right_target,
    output ret_en, taken, ret_pc, ret_index
  );
endinterface

// File: rtl/btb_ras_param.sv
// Fully associative branch target buffer with 2-bit direction counters and a
// circular return address stack. Lookup is combinational on pre-edge state;
// all updates commit on the clock edge after operate_en.
// Optional macro BTB_STAT_EN adds stat_hits / stat_miss event counters.
module btb_ras_param #(
  parameter int         ENTRIES    = 32,
  parameter int         RAS_DEPTH  = 8,
  parameter logic [1:0] CNT_INIT_T = 2'b10
) (
  input  logic               clk,
  input  logic               reset,
  btb_ras_param_if.slave     bus
`ifdef BTB_STAT_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_miss
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [RAS_W:0] RAS_FULL = (RAS_W+1)'(RAS_DEPTH);

  // BTB state: valid is control (reset), payload is data (no reset)
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] isret_q, isret_d;
  logic [29:0]        tag_q [ENTRIES];
  logic [29:0]        tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  // RAS state: top points at the next free slot, cnt counts live slots
  logic [31:0]        ras_q [RAS_DEPTH];
  logic [31:0]        ras_d [RAS_DEPTH];
  logic [RAS_W-1:0]   ras_top_q, ras_top_d;
  logic [RAS_W:0]     ras_cnt_q, ras_cnt_d;
  logic [RAS_W-1:0]   ras_top_m1;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               op_hit;
  logic [IDX_W-1:0]   op_hit_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   oi;
  logic [31:0]        push_val;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^bus.fetch_pc[1:0];
  assign oi            = bus.operate_index;
  assign ras_top_m1    = ras_top_q - RAS_W'(1);
  assign push_val      = bus.operate_pc + 32'd4;

  // Saturating one-step move of a 2-bit counter toward a direction
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Fetch-side tag match, lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == bus.fetch_pc[31:2])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Prediction outputs: counter/target for normal entries, RAS top for returns
  always_comb begin
    bus.ret_en    = 1'b0;
    bus.taken     = 1'b0;
    bus.ret_pc    = '0;
    bus.ret_index = '0;
    if (bus.fetch_en && hit) begin
      bus.ret_en    = 1'b1;
      bus.ret_index = hit_idx;
      if (isret_q[hit_idx]) begin
        bus.taken  = (ras_cnt_q != '0);
        bus.ret_pc = (ras_cnt_q != '0) ? ras_q[ras_top_m1] : 32'd0;
      end else begin
        bus.taken  = cnt_q[hit_idx][1];
        bus.ret_pc = tgt_q[hit_idx];
      end
    end
  end

  // Allocation search: existing entry for operate_pc, else lowest free slot
  always_comb begin
    op_hit     = 1'b0;
    op_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!op_hit && valid_q[i] && (tag_q[i] == bus.operate_pc[31:2])) begin
        op_hit     = 1'b1;
        op_hit_idx = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    alloc_idx = rr_ptr_q;
    if (op_hit)          alloc_idx = op_hit_idx;
    else if (free_found) alloc_idx = free_idx;
  end

  // BTB next state: per-entry updates, then allocation, delete has final say
  always_comb begin
    valid_d  = valid_q;
    isret_d  = isret_q;
    tag_d    = tag_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.operate_en) begin
      if (valid_q[oi]) begin
        if (bus.pre_error)      cnt_d[oi] = sat_step(cnt_q[oi], bus.right_orien);
        else if (bus.pre_right) cnt_d[oi] = sat_step(cnt_q[oi], cnt_q[oi][1]);
        if (bus.target_error)   tgt_d[oi] = bus.right_target;
      end
      if (bus.add_entry && !bus.delete_entry) begin
        valid_d[alloc_idx] = 1'b1;
        isret_d[alloc_idx] = bus.pop_ras;
        tag_d[alloc_idx]   = bus.operate_pc[31:2];
        tgt_d[alloc_idx]   = bus.right_target;
        cnt_d[alloc_idx]   = bus.right_orien ? CNT_INIT_T : 2'b01;
        if (!op_hit && !free_found) rr_ptr_d = rr_ptr_q + IDX_W'(1);
      end
      if (bus.delete_entry) valid_d[oi] = 1'b0;
    end
  end

  // RAS next state: push, pop, or replace-top when both are requested
  always_comb begin
    ras_d     = ras_q;
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    if (bus.operate_en) begin
      if (bus.push_ras && bus.pop_ras) begin
        ras_d[ras_top_m1] = push_val;
        if (ras_cnt_q == '0) ras_cnt_d = (RAS_W+1)'(1);
      end else if (bus.push_ras) begin
        ras_d[ras_top_q] = push_val;
        ras_top_d        = ras_top_q + RAS_W'(1);
        if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + (RAS_W+1)'(1);
      end else if (bus.pop_ras && (ras_cnt_q != '0)) begin
        ras_top_d = ras_top_m1;
        ras_cnt_d = ras_cnt_q - (RAS_W+1)'(1);
      end
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      rr_ptr_q  <= '0;
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rr_ptr_q  <= rr_ptr_d;
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Payload registers, meaningful only behind a valid bit or live RAS slot
  always_ff @(posedge clk) begin
    isret_q <= isret_d;
    tag_q   <= tag_d;
    tgt_q   <= tgt_d;
    cnt_q   <= cnt_d;
    ras_q   <= ras_d;
  end

`ifdef BTB_STAT_EN
  logic [31:0] stat_hits_q, stat_miss_q;

  // Free-running hit and misprediction event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits_q <= '0;
      stat_miss_q <= '0;
    end else begin
      if (bus.fetch_en && bus.ret_en) stat_hits_q <= stat_hits_q + 32'd1;
      if (bus.operate_en && (bus.pre_error || bus.target_error))
        stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_hits = stat_hits_q;
  assign stat_miss = stat_miss_q;
`endif

endmodule
